// File: rtl/pc_sequencer.sv
// MIPS fetch-stage program counter: stall, branch/jump redirect with optional delay slot,
// exception entry, eret. Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_sequencer #(
    parameter int unsigned          WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = WORD_SIZE'(32'h0000_0080),
    parameter int unsigned          INC          = 4,
    parameter int unsigned          DELAY_SLOT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 br_en,
    input  logic [WORD_SIZE-1:0] br_addr,
    input  logic                 exc_en,
    input  logic                 eret_en,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] pc_seq,
    output logic [WORD_SIZE-1:0] epc_out,
    output logic                 bd_out,
    output logic                 align_fault
);

    localparam logic [WORD_SIZE-1:0] INC_W = WORD_SIZE'(INC);

    typedef enum logic {
        SEQ,
        PEND
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] target;
    logic [WORD_SIZE-1:0] epc;
    logic                 bd;
    logic                 fault;
    logic                 eret_bad;
    logic                 br_bad;

`ifdef PC_ALIGN_CHECK_EN
    // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits.
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = INC_W - 1'b1;

    assign eret_bad = (epc & ALIGN_MASK) != '0;
    assign br_bad   = (br_addr & ALIGN_MASK) != '0;
`else
    assign eret_bad = 1'b0;
    assign br_bad   = 1'b0;
`endif

    assign pc_out      = pc;
    assign pc_seq      = pc + INC_W;
    assign epc_out     = epc;
    assign bd_out      = bd;
    assign align_fault = fault;

    // NOTE: every register here uses <= so all updates see the pre-edge values of pc/state/epc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_VECTOR;
            state  <= SEQ;
            target <= '0;
            epc    <= '0;
            bd     <= 1'b0;
            fault  <= 1'b0;
        end else begin
            fault <= 1'b0;
            if (exc_en) begin
                pc     <= EXC_VECTOR;
                state  <= SEQ;
                target <= '0;
                // In PEND the faulting instruction is the branch that precedes the delay slot.
                if (state == PEND) begin
                    epc <= pc - INC_W;
                    bd  <= 1'b1;
                end else begin
                    epc <= pc;
                    bd  <= 1'b0;
                end
            end else if (stall) begin
                // Everything holds; redirect requests seen now are the requester's to repeat.
            end else if (eret_en) begin
                if (eret_bad) begin
                    pc     <= EXC_VECTOR;
                    epc    <= pc;
                    bd     <= 1'b0;
                    fault  <= 1'b1;
                end else begin
                    pc     <= epc;
                end
                state  <= SEQ;
                target <= '0;
            end else if (state == PEND) begin
                pc    <= target;
                state <= SEQ;
            end else if (br_en) begin
                if (br_bad) begin
                    pc    <= EXC_VECTOR;
                    epc   <= pc;
                    bd    <= 1'b0;
                    fault <= 1'b1;
                end else if (DELAY_SLOT != 0) begin
                    pc     <= pc + INC_W;
                    target <= br_addr;
                    state  <= PEND;
                end else begin
                    pc <= br_addr;
                end
            end else begin
                pc <= pc + INC_W;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (defaults, DELAY_SLOT=1): directed plan then random traffic
// against a queue-based reference model. Expectations follow PC_ALIGN_CHECK_EN when defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_en;
    logic [31:0] br_addr;
    logic        exc_en;
    logic        eret_en;
    logic [31:0] pc_out;
    logic [31:0] pc_seq;
    logic [31:0] epc_out;
    logic        bd_out;
    logic        align_fault;

    int tests  = 0;
    int failed = 0;

    // Reference state: the redirect queue holds a target still owed after its delay slot.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_bd;
    logic        m_fault;
    logic [31:0] m_redirect[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .WORD_SIZE   (32),
        .RESET_VECTOR(32'h0),
        .EXC_VECTOR  (32'h80),
        .INC         (4),
        .DELAY_SLOT  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .exc_en     (exc_en),
        .eret_en    (eret_en),
        .pc_out     (pc_out),
        .pc_seq     (pc_seq),
        .epc_out    (epc_out),
        .bd_out     (bd_out),
        .align_fault(align_fault)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return (a % 4) != 0;
`else
        return (a % 4) != 0 && 1'b0;
`endif
    endfunction

    task automatic model_fault_entry();
        m_epc   = m_pc;
        m_bd    = 1'b0;
        m_pc    = 32'h80;
        m_fault = 1'b1;
        m_redirect.delete();
    endtask

    task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] a,
                              input bit e, input bit er);
        m_fault = 1'b0;
        if (!r) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            m_bd  = 1'b0;
            m_redirect.delete();
        end else if (e) begin
            m_bd  = m_redirect.size() != 0;
            m_epc = m_bd ? m_pc - 32'd4 : m_pc;
            m_pc  = 32'h80;
            m_redirect.delete();
        end else if (s) begin
            // nothing moves
        end else if (er) begin
            if (misaligned(m_epc)) model_fault_entry();
            else begin
                m_pc = m_epc;
                m_redirect.delete();
            end
        end else if (m_redirect.size() != 0) begin
            m_pc = m_redirect.pop_front();
        end else if (b) begin
            if (misaligned(a)) model_fault_entry();
            else begin
                m_redirect.push_back(a);
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit s, input bit b,
                        input logic [31:0] a, input bit e, input bit er);
        reset   = r;
        stall   = s;
        br_en   = b;
        br_addr = a;
        exc_en  = e;
        eret_en = er;
        model_step(r, s, b, a, e, er);
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc_out, m_pc);
        check({tag, ".pc_seq"}, pc_seq, m_pc + 32'd4);
        check({tag, ".epc"}, epc_out, m_epc);
        check({tag, ".bd"}, {31'b0, bd_out}, {31'b0, m_bd});
        check({tag, ".fault"}, {31'b0, align_fault}, {31'b0, m_fault});
    endtask

    task automatic run(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; br_en = 1'b0; br_addr = '0; exc_en = 1'b0; eret_en = 1'b0;
        m_pc = '0; m_epc = '0; m_bd = 1'b0; m_fault = 1'b0;

        // Reset then sequential run
        step("reset0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        check("reset_pc", pc_out, 32'h0);
        check("reset_epc", epc_out, 32'h0);
        run("seq1"); check("seq1_const", pc_out, 32'h4);
        run("seq2"); check("seq2_const", pc_out, 32'h8);
        run("seq3"); check("seq3_const", pc_out, 32'hC);
        run("seq4");

        // Delay-slot branch with a stalled PEND
        step("br200", 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        check("ds_slot", pc_out, 32'h14);
        for (int i = 0; i < 3; i++) begin
            step("pend_stall", 1'b1, 1'b1, 1'b1, 32'h999 & ~32'h3, 1'b0, 1'b1);
            check("pend_hold", pc_out, 32'h14);
        end
        run("tgt"); check("ds_target", pc_out, 32'h200);
        run("tgt1"); check("ds_target1", pc_out, 32'h204);

        // Exception (with stall) in a delay slot, then eret
        step("rst_b", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run("seq_b");
        step("br200b", 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        step("exc_ds", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("exc_pc", pc_out, 32'h80);
        check("exc_epc", epc_out, 32'h10);
        check("exc_bd", {31'b0, bd_out}, 32'h1);
        run("exc_seq");
        step("eret", 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
        check("eret_pc", pc_out, 32'h10);
        run("post_eret");

        // Wrap, then reset in the PEND cycle
        step("br_top", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        run("top0");
        run("top1"); check("top_pc", pc_out, 32'hFFFF_FFFC);
        run("wrap"); check("wrap_pc", pc_out, 32'h0);
        step("br300", 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        step("rst_pend", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_pend_pc", pc_out, 32'h0);
        run("after_rst"); check("no_stale_tgt", pc_out, 32'h4);
        run("after_rst1");

        // Misaligned branch target from pc 0x40
        step("br3c", 1'b1, 1'b0, 1'b1, 32'h3C, 1'b0, 1'b0);
        run("to3c");
        run("to40"); check("at40", pc_out, 32'h40);
        step("br102", 1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", pc_out, 32'h80);
        check("align_epc", epc_out, 32'h40);
        check("align_pulse", {31'b0, align_fault}, 32'h1);
        run("align_after");
        check("align_clear", {31'b0, align_fault}, 32'h0);
`else
        check("noalign_slot", pc_out, 32'h44);
        run("noalign_tgt");
        check("noalign_pc", pc_out, 32'h102);
        check("noalign_fault", {31'b0, align_fault}, 32'h0);
`endif

        // Random traffic against the model
        step("rst_rand", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(7) != 0) a = a & ~32'h3;
            step("rand",
                 $urandom_range(49) != 0,
                 $urandom_range(4) == 0,
                 $urandom_range(3) == 0,
                 a,
                 $urandom_range(19) == 0,
                 $urandom_range(14) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
